// File: rtl/mod_addsub_pipe_pkg.sv
// rtl/mod_addsub_pipe_pkg.sv - shared types and lane-slice helper for the modular add/sub pipe
package mod_arith_pkg;

  localparam int DEFAULT_K = 8;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} modop_e;

  // Low bit index of lane `lane` in a packed LANES x width vector.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// rtl/mod_addsub_pipe_if.sv - valid/ready operand and result bus (MOD_ADDSUB_RANGE_CHECK_EN adds range_err)
interface mod_addsub_pipe_if #(
  parameter int K     = 8,
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               op;
  logic [LANES*K-1:0] a;
  logic [LANES*K-1:0] b;
  logic [K-1:0]       mod;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*K-1:0] result;
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  logic [LANES-1:0]   range_err;

  modport master (output in_valid, op, a, b, mod, out_ready,
                  input  in_ready, out_valid, result, range_err);
  modport slave  (input  in_valid, op, a, b, mod, out_ready,
                  output in_ready, out_valid, result, range_err);
`else
  modport master (output in_valid, op, a, b, mod, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, op, a, b, mod, out_ready,
                  output in_ready, out_valid, result);
`endif
endinterface

// File: rtl/mod_addsub_pipe_lane.sv
// rtl/mod_addsub_pipe_lane.sv - one lane: S1 raw sum/difference, S2 modular correction (MOD_ADDSUB_RANGE_CHECK_EN adds operand range flag)
module mod_addsub_lane
  import mod_arith_pkg::*;
#(
  parameter int K = DEFAULT_K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en1,
  input  logic         i_en2,
  input  modop_e       i_op,
  input  modop_e       i_op_s1,
  input  logic [K-1:0] i_a,
  input  logic [K-1:0] i_b,
  input  logic [K-1:0] i_mod_s1,
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  input  logic [K-1:0] i_mod,
  output logic         o_range_err,
`endif
  output logic [K-1:0] o_result
);

  logic [K:0]   w_raw_next;
  logic [K:0]   r_raw;
  logic [K:0]   w_diff;
  logic [K-1:0] w_corr;
  logic [K-1:0] r_result;

  // Raw K+1 bit sum or two's-complement difference of the incoming operands.
  always_comb begin
    w_raw_next = {1'b0, i_a} + {1'b0, i_b};
    if (i_op == OP_SUB) w_raw_next = {1'b0, i_a} - {1'b0, i_b};
  end

  // Fold the raw value back into [0, q): subtract q on add overflow, add q on borrow.
  always_comb begin
    w_diff = r_raw - {1'b0, i_mod_s1};
    w_corr = r_raw[K-1:0];
    if (i_op_s1 == OP_ADD) begin
      if (r_raw >= {1'b0, i_mod_s1}) w_corr = w_diff[K-1:0];
    end else begin
      if (r_raw[K]) w_corr = r_raw[K-1:0] + i_mod_s1;
    end
  end

  // Stage registers: raw value loads on accept, result loads when S2 takes a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raw    <= '0;
      r_result <= '0;
    end else begin
      if (i_en1) r_raw <= w_raw_next;
      if (i_en2) r_result <= w_corr;
    end
  end

  assign o_result = r_result;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  logic r_rerr1;
  logic r_rerr2;

  // Operand range flag, captured with the beat and carried alongside its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rerr1 <= 1'b0;
      r_rerr2 <= 1'b0;
    end else begin
      if (i_en1) r_rerr1 <= (i_a >= i_mod) || (i_b >= i_mod);
      if (i_en2) r_rerr2 <= r_rerr1;
    end
  end

  assign o_range_err = r_rerr2;
`endif

endmodule

// File: rtl/mod_addsub_pipe.sv
// rtl/mod_addsub_pipe.sv - two-stage elastic multi-lane modular adder/subtractor (optional MOD_ADDSUB_RANGE_CHECK_EN)
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int K     = DEFAULT_K,
  parameter int LANES = 4
) (
  input logic               clk,
  input logic               rst,
  mod_addsub_pipe_if.slave  bus
);

  logic               r_v1;
  logic               r_v2;
  modop_e             r_op;
  logic [K-1:0]       r_mod;
  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_accept;
  logic               w_s2_load;
  logic [LANES*K-1:0] w_result;

  // S2 drains when empty or consumer ready; S1 moves whenever S2 does or it is empty.
  always_comb begin
    w_s2_adv  = !r_v2 || bus.out_ready;
    w_s1_adv  = !r_v1 || w_s2_adv;
    w_accept  = bus.in_valid && w_s1_adv;
    w_s2_load = w_s2_adv && r_v1;
  end

  // Stage valids plus the op/modulus shared by every lane of the beat in S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_op  <= OP_ADD;
      r_mod <= '0;
    end else begin
      if (w_s1_adv) r_v1 <= bus.in_valid;
      if (w_s2_adv) r_v2 <= r_v1;
      if (w_accept) begin
        r_op  <= modop_e'(bus.op);
        r_mod <= bus.mod;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mod_addsub_lane #(.K(K)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .i_en1       (w_accept),
      .i_en2       (w_s2_load),
      .i_op        (modop_e'(bus.op)),
      .i_op_s1     (r_op),
      .i_a         (bus.a[lane_lo(g, K) +: K]),
      .i_b         (bus.b[lane_lo(g, K) +: K]),
      .i_mod_s1    (r_mod),
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
      .i_mod       (bus.mod),
      .o_range_err (bus.range_err[g]),
`endif
      .o_result    (w_result[lane_lo(g, K) +: K])
    );
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_v2;
  assign bus.result    = w_result;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb/tb_mod_addsub_pipe.sv - randomized scoreboard bench for mod_addsub_pipe
module tb_mod_addsub_pipe;

  localparam int K     = 8;
  localparam int LANES = 4;

  typedef struct {
    logic [LANES*K-1:0] res;
    logic [LANES-1:0]   rerr;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b0;
  bit   prev_stall = 1'b0;
  bit   last_acc = 1'b0;
  exp_t sb[$];

  mod_addsub_pipe_if #(.K(K), .LANES(LANES)) bus ();

  mod_addsub_pipe #(.K(K), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Modular arithmetic on plain integers; illegal operands follow the documented raw/correct rule.
  function automatic exp_t model(input bit op, input logic [LANES*K-1:0] a,
                                 input logic [LANES*K-1:0] b, input logic [K-1:0] q, input int c);
    exp_t e;
    e.res = '0;
    e.rerr = '0;
    e.cyc = c;
    for (int i = 0; i < LANES; i++) begin
      int av, bv, qv, r;
      av = int'(a[i*K +: K]);
      bv = int'(b[i*K +: K]);
      qv = int'(q);
      if (!op) begin
        r = av + bv;
        if (r >= qv) r = r - qv;
      end else begin
        r = av - bv;
        if (r < 0) r = r + qv;
      end
      r = r & 255;
      e.res[i*K +: K] = r[K-1:0];
      e.rerr[i] = (av >= qv) || (bv >= qv);
    end
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (prev_stall) chk("valid_hold", bus.out_valid, 1);
    if (bus.out_valid && sb.size() == 0) chk("spurious_out", bus.out_valid, 0);
    if (bus.out_valid && sb.size() > 0) begin
      if (bus.out_ready) begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        chk("range_err", bus.range_err, e.rerr);
`endif
        if (lat_chk) chk("latency", cyc - e.cyc, 2);
      end else begin
        chk("stall_hold", bus.result, sb[0].res);
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready && !rst;
    last_acc = bus.in_valid && bus.in_ready && !rst;
    if (last_acc) sb.push_back(model(bus.op, bus.a, bus.b, bus.mod, cyc));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input bit op, input logic [LANES*K-1:0] a, input logic [LANES*K-1:0] b,
                      input logic [K-1:0] q);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.mod = q;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      cycle();
      if (last_acc) break;
    end
    chk("send_timeout", last_acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 50 && sb.size() > 0; n++) cycle();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic rand_beat(output bit op, output logic [LANES*K-1:0] a,
                           output logic [LANES*K-1:0] b, output logic [K-1:0] q);
    int qv;
    qv = $urandom_range(2, 255);
    q = qv[K-1:0];
    op = $urandom_range(0, 1);
    for (int i = 0; i < LANES; i++) begin
      a[i*K +: K] = $urandom_range(0, qv - 1);
      b[i*K +: K] = $urandom_range(0, qv - 1);
    end
  endtask

  initial begin
    bit               op;
    logic [LANES*K-1:0] a, b;
    logic [K-1:0]     q;
    int               cnt, start;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.mod = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_result", bus.result, 0);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    chk("rst_range_err", bus.range_err, 0);
`endif
    rst = 1'b0;

    // Basic arithmetic, q=17.
    bus.out_ready = 1'b1;
    send(1'b0, {8'd8, 8'd0, 8'd16, 8'd9}, {8'd8, 8'd0, 8'd16, 8'd12}, 8'd17);
    send(1'b1, {8'd10, 8'd0, 8'd16, 8'd3}, {8'd2, 8'd16, 8'd16, 8'd5}, 8'd17);
    drain();

    // Boundary moduli, q changing beat to beat.
    send(1'b0, {24'd0, 8'd254}, {24'd0, 8'd254}, 8'd255);
    send(1'b1, {24'd0, 8'd0}, {24'd0, 8'd254}, 8'd255);
    send(1'b0, {8'd1, 8'd1, 8'd0, 8'd1}, {8'd1, 8'd0, 8'd1, 8'd1}, 8'd2);
    drain();

    // Streaming: 8 back-to-back beats, alternating op, with latency tracking.
    lat_chk = 1'b1;
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      rand_beat(op, a, b, q);
      send(i[0], a, b, q);
    end
    chk("stream_cycles", cyc - start, 8);
    drain();
    lat_chk = 1'b0;

    // Back-pressure: only two beats fit.
    bus.out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      rand_beat(op, a, b, q);
      bus.op = op; bus.a = a; bus.b = b; bus.mod = q;
      bus.in_valid = 1'b1;
      cycle();
      if (last_acc) cnt++;
    end
    chk("bp_accepted", cnt, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    cycle();
    drain();

    // Reset with two beats buffered.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_beat(op, a, b, q);
      send(op, a, b, q);
    end
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (5) cycle();

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    // Out-of-range operands on lanes 0 and 1, then a legal beat.
    send(1'b0, {8'd1, 8'd2, 8'd5, 8'd20}, {8'd1, 8'd2, 8'd17, 8'd3}, 8'd17);
    send(1'b0, {8'd1, 8'd2, 8'd5, 8'd16}, {8'd1, 8'd2, 8'd16, 8'd3}, 8'd17);
    drain();
`endif

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      rand_beat(op, a, b, q);
      bus.op = op; bus.a = a; bus.b = b; bus.mod = q;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
